// File: rtl/opb_register_bank_ppc2simulink_pkg.sv
// Shared types, constants and byte-merge helper for the OPB register bank.
package opb_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RECOVER = 2'd2
  } state_e;

  localparam int unsigned REG_W           = 32;
  localparam int unsigned BYTES           = 4;
  // Commit bit position in OPB bit order (bit 0 = MSB)
  localparam int unsigned CTRL_COMMIT_BIT = 31;
  // Same bit and its byte lane in conventional [31:0] numbering
  localparam int unsigned COMMIT_LSB_BIT  = REG_W - 1 - CTRL_COMMIT_BIT;
  localparam int unsigned COMMIT_LANE     = COMMIT_LSB_BIT / 8;

  // Transfer request captured when a hit is accepted
  typedef struct packed {
    logic             rnw;
    logic             mapped;
    logic [BYTES-1:0] be;
    logic [REG_W-1:0] data;
  } req_t;

  // Replace only the byte lanes whose enable is set; be[BYTES-1] is the MSB lane
  function automatic logic [REG_W-1:0] be_merge(input logic [REG_W-1:0] old_val,
                                                input logic [REG_W-1:0] new_val,
                                                input logic [BYTES-1:0] be);
    logic [REG_W-1:0] res;
    res = old_val;
    for (int b = 0; b < int'(BYTES); b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave-side bus signals in native OPB bit order (bit 0 = MSB).
interface opb_register_bank_ppc2simulink_if;

  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

endinterface

// File: rtl/opb_register_bank_ppc2simulink_decode.sv
// Address decode: window hit, word index and mapped-word flag (combinational).
module opb_regbank_decode #(
  parameter int unsigned               C_OPB_AWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0]   C_BASEADDR   = 32'h0100C000,
  parameter logic [C_OPB_AWIDTH-1:0]   C_HIGHADDR   = 32'h0100C0FF,
  parameter int unsigned               IDX_W        = 6,
  parameter int unsigned               C_MAPPED     = 4
) (
  input  logic [C_OPB_AWIDTH-1:0] abus,
  input  logic                    select,
  output logic                    hit_c,
  output logic [IDX_W-1:0]        idx_c,
  output logic                    mapped_c
);

  logic [C_OPB_AWIDTH-1:0] offset;

  // Window compare and word index; the two byte-offset bits are dropped
  always_comb begin
    offset   = abus - C_BASEADDR;
    hit_c    = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
    idx_c    = IDX_W'(offset >> 2);
    mapped_c = (32'(idx_c) < C_MAPPED);
  end

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank driving C_N_REGS user registers into the fabric.
// Optional feature: define SHADOW_COMMIT_EN for shadowed writes with an
// atomic commit through the control word at index C_N_REGS.
module opb_register_bank_ppc2simulink
  import opb_regbank_pkg::*;
#(
  parameter int unsigned             C_OPB_AWIDTH = 32,
  parameter int unsigned             C_OPB_DWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h0100C000,
  parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h0100C0FF,
  parameter int unsigned             C_N_REGS     = 4,
  parameter logic [REG_W-1:0]        C_RESET_VAL  = '0
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst_n,
  opb_register_bank_ppc2simulink_if.slave bus,
  output logic [REG_W*C_N_REGS-1:0]   user_data_out,
  output logic [C_N_REGS-1:0]         user_data_valid
);

  localparam int unsigned WIN_BYTES = 32'(C_HIGHADDR - C_BASEADDR) + 1;
  localparam int unsigned IDX_W     = $clog2(WIN_BYTES) - 2;
`ifdef SHADOW_COMMIT_EN
  localparam int unsigned C_MAPPED  = C_N_REGS + 1;
`else
  localparam int unsigned C_MAPPED  = C_N_REGS;
`endif

  state_e                  state_q, state_d;
  logic                    hit_c, mapped_c;
  logic [IDX_W-1:0]        idx_c, idx_q;
  logic [BYTES-1:0]        be_in;
  logic [C_OPB_DWIDTH-1:0] wdata_in;
  req_t                    req_d, req_q;
  logic                    capture_c, apply_c, wr_c;
  logic                    ack_d, err_d, ack_q, err_q;
  logic [REG_W-1:0]        dbus_d, dbus_q, rd_c;
  logic [C_N_REGS-1:0]     wr_sel_c;
  logic [C_N_REGS-1:0]     valid_q;
  logic [REG_W-1:0]        regs_q [C_N_REGS];
`ifdef SHADOW_COMMIT_EN
  logic [REG_W-1:0]        shadow_q [C_N_REGS];
  logic                    commit_c;
`endif
  logic                    unused_seq;

  assign unused_seq = bus.OPB_seqAddr;
  assign be_in      = bus.OPB_BE;
  assign wdata_in   = bus.OPB_DBus;
  assign req_d      = '{rnw: bus.OPB_RNW, mapped: mapped_c, be: be_in, data: REG_W'(wdata_in)};

  opb_regbank_decode #(
    .C_OPB_AWIDTH (C_OPB_AWIDTH),
    .C_BASEADDR   (C_BASEADDR),
    .C_HIGHADDR   (C_HIGHADDR),
    .IDX_W        (IDX_W),
    .C_MAPPED     (C_MAPPED)
  ) u_decode (
    .abus     (bus.OPB_ABus),
    .select   (bus.OPB_select),
    .hit_c    (hit_c),
    .idx_c    (idx_c),
    .mapped_c (mapped_c)
  );

  // Read mux on the live index; the control word and unmapped words read 0
  always_comb begin
    rd_c = '0;
    for (int unsigned i = 0; i < C_N_REGS; i++) begin
`ifdef SHADOW_COMMIT_EN
      if (idx_c == IDX_W'(i)) rd_c = shadow_q[i];
`else
      if (idx_c == IDX_W'(i)) rd_c = regs_q[i];
`endif
    end
  end

  // FSM state register
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state and next bus outputs; one ack per accepted hit, then a recovery cycle
  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    dbus_d    = '0;
    capture_c = 1'b0;
    apply_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit_c) begin
          state_d   = ACK;
          capture_c = 1'b1;
          ack_d     = 1'b1;
          err_d     = !mapped_c;
          if (bus.OPB_RNW && mapped_c) dbus_d = rd_c;
        end
      end
      ACK: begin
        state_d = RECOVER;
        apply_c = 1'b1;
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered bus outputs and captured request
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      dbus_q <= '0;
      req_q  <= '0;
      idx_q  <= '0;
    end else begin
      ack_q  <= ack_d;
      err_q  <= err_d;
      dbus_q <= dbus_d;
      if (capture_c) begin
        req_q <= req_d;
        idx_q <= idx_c;
      end
    end
  end

  // Write decode for the ACK cycle; an all-zero byte enable is a no-op
  always_comb begin
    wr_c = apply_c && !req_q.rnw && req_q.mapped && (req_q.be != '0);
    wr_sel_c = '0;
    for (int unsigned i = 0; i < C_N_REGS; i++) begin
      wr_sel_c[i] = wr_c && (idx_q == IDX_W'(i));
    end
  end

`ifdef SHADOW_COMMIT_EN
  assign commit_c = wr_c && (idx_q == IDX_W'(C_N_REGS)) &&
                    req_q.data[COMMIT_LSB_BIT] && req_q.be[COMMIT_LANE];

  // Writes land in shadows; a commit copies every shadow out at once
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int unsigned i = 0; i < C_N_REGS; i++) begin
        regs_q[i]   <= C_RESET_VAL;
        shadow_q[i] <= C_RESET_VAL;
      end
      valid_q <= '0;
    end else begin
      valid_q <= '0;
      for (int unsigned i = 0; i < C_N_REGS; i++) begin
        if (wr_sel_c[i]) shadow_q[i] <= be_merge(shadow_q[i], req_q.data, req_q.be);
      end
      if (commit_c) begin
        for (int unsigned i = 0; i < C_N_REGS; i++) regs_q[i] <= shadow_q[i];
        valid_q <= '1;
      end
    end
  end
`else
  // Writes go straight to the user registers with a per-register update strobe
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int unsigned i = 0; i < C_N_REGS; i++) regs_q[i] <= C_RESET_VAL;
      valid_q <= '0;
    end else begin
      valid_q <= '0;
      for (int unsigned i = 0; i < C_N_REGS; i++) begin
        if (wr_sel_c[i]) begin
          regs_q[i]  <= be_merge(regs_q[i], req_q.data, req_q.be);
          valid_q[i] <= 1'b1;
        end
      end
    end
  end
`endif

  // Flatten register array onto the user bus, reg i at bits [32*i+31:32*i]
  for (genvar g = 0; g < int'(C_N_REGS); g++) begin : g_out
    assign user_data_out[REG_W*g +: REG_W] = regs_q[g];
  end

  assign user_data_valid = valid_q;
  assign bus.Sl_xferAck  = ack_q;
  assign bus.Sl_errAck   = err_q;
  assign bus.Sl_DBus     = dbus_q;
  assign bus.Sl_retry    = 1'b0;
  assign bus.Sl_toutSup  = 1'b0;

endmodule
